// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU operation codes plus the GBR
// read-modify-write opcode and sequencer state encodings.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_AND = 4'd1,
    ALU_OR  = 4'd2,
    ALU_XOR = 4'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    RMW_AND = 2'b00,
    RMW_OR  = 2'b01,
    RMW_XOR = 2'b10,
    RMW_TST = 2'b11
  } rmw_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    RD   = 3'd2,
    OP   = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } rmw_state_t;

  // TST is a non-destructive AND; only the T bit is updated.
  function automatic alu_op_t rmw_alu_code(input rmw_op_t op);
    case (op)
      RMW_AND: rmw_alu_code = ALU_AND;
      RMW_OR:  rmw_alu_code = ALU_OR;
      RMW_XOR: rmw_alu_code = ALU_XOR;
      default: rmw_alu_code = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/gbr_rmw_ctrl.sv
// Sequencer for AND.B/OR.B/XOR.B/TST.B #imm,@(R0,GBR): borrows the shared ALU for
// address and logic op, runs the byte read/write. Optional watchdog: GBR_RMW_TIMEOUT_EN.
module gbr_rmw_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [REG_WIDTH-1:0] r0,
  input  logic [REG_WIDTH-1:0] gbr,
  input  logic [7:0]           imm,
  output logic                 ready,
  output logic                 done,
  output logic                 t_we,
  output logic                 t_val,
  output logic                 err,
  output logic [REG_WIDTH-1:0] alu_op_a,
  output logic [REG_WIDTH-1:0] alu_op_b,
  output logic [REG_WIDTH-1:0] alu_operation,
  output logic                 alu_carry_in,
  input  logic [REG_WIDTH-1:0] alu_result,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  output logic [2:0]           state
);

  // Handshakes: a start is taken on a rising edge where start && ready. A memory
  // access is in flight while mem_req is high; mem_we/mem_addr/mem_wdata hold
  // steady until the edge that samples mem_ack high, which ends the access.

  rmw_state_t cur;
  rmw_op_t    op_q;
  logic [7:0] imm_q;

  assign alu_carry_in = 1'b0;
  assign state        = cur;

`ifdef GBR_RMW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cur           <= IDLE;
      op_q          <= RMW_AND;
      imm_q         <= '0;
      ready         <= 1'b1;
      done          <= 1'b0;
      t_we          <= 1'b0;
      t_val         <= 1'b0;
      alu_op_a      <= '0;
      alu_op_b      <= '0;
      alu_operation <= REG_WIDTH'(ALU_ADD);
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
`ifdef GBR_RMW_TIMEOUT_EN
      err           <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      done  <= 1'b0;
      t_we  <= 1'b0;
      t_val <= 1'b0;
`ifdef GBR_RMW_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (cur)
        IDLE: begin
          if (start) begin
            op_q          <= rmw_op_t'(op);
            imm_q         <= imm;
            alu_op_a      <= r0;
            alu_op_b      <= gbr;
            alu_operation <= REG_WIDTH'(ALU_ADD);
            ready         <= 1'b0;
            cur           <= ADDR;
          end
        end

        // Effective address wraps at 2^REG_WIDTH; the ALU carry-out is unused.
        ADDR: begin
          mem_addr <= alu_result;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          alu_op_a <= '0;
          alu_op_b <= '0;
`ifdef GBR_RMW_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          cur      <= RD;
        end

        RD: begin
          if (mem_ack) begin
            mem_req       <= 1'b0;
            alu_op_a      <= REG_WIDTH'(mem_rdata);
            alu_op_b      <= REG_WIDTH'(imm_q);
            alu_operation <= REG_WIDTH'(rmw_alu_code(op_q));
            cur           <= OP;
          end
`ifdef GBR_RMW_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            ready   <= 1'b1;
            cur     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        OP: begin
          alu_op_a      <= '0;
          alu_op_b      <= '0;
          alu_operation <= REG_WIDTH'(ALU_ADD);
          if (op_q == RMW_TST) begin
            t_val <= (alu_result[7:0] == 8'h00);
            t_we  <= 1'b1;
            done  <= 1'b1;
            cur   <= DONE;
          end else begin
            mem_wdata <= alu_result[7:0];
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
`ifdef GBR_RMW_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            cur       <= WR;
          end
        end

        WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            cur     <= DONE;
          end
`ifdef GBR_RMW_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            ready   <= 1'b1;
            cur     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        DONE: begin
          ready <= 1'b1;
          cur   <= IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          ready   <= 1'b1;
          cur     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbr_rmw_ctrl.sv
// Directed bench for gbr_rmw_ctrl: driver issues operations and queues expected
// completions; a negedge process plays memory/ALU and scores each completion.
module tb_gbr_rmw_ctrl;

  localparam int RW = 32;
  localparam int W  = 52;

  logic          clock = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [RW-1:0] r0, gbr;
  logic [7:0]    imm;
  logic          ready, done, t_we, t_val, err;
  logic [RW-1:0] alu_op_a, alu_op_b, alu_operation, alu_result;
  logic          alu_carry_in;
  logic          mem_req, mem_we, mem_ack;
  logic [RW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [2:0]    dut_state;

  gbr_rmw_ctrl #(.REG_WIDTH(RW), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .rst(rst), .start(start), .op(op), .r0(r0), .gbr(gbr), .imm(imm),
    .ready(ready), .done(done), .t_we(t_we), .t_val(t_val), .err(err),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_operation(alu_operation),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state(dut_state)
  );

  always #5 clock = ~clock;

  // External ALU: codes 0 ADD, 1 AND, 2 OR, 3 XOR.
  always_comb begin
    alu_result = alu_op_a + alu_op_b;
    case (alu_operation)
      32'd1: alu_result = alu_op_a & alu_op_b;
      32'd2: alu_result = alu_op_a | alu_op_b;
      32'd3: alu_result = alu_op_a ^ alu_op_b;
      default: alu_result = alu_op_a + alu_op_b;
    endcase
  end

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [logic [31:0]];
  int         rd_waits = 0;
  int         wr_waits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input int lat, input logic tw, input logic tv,
                                          input logic wr, input logic e,
                                          input logic [31:0] addr, input logic [7:0] data);
    mk_exp = {8'(lat), tw, tv, wr, e, addr, data};
  endfunction

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    rd_mem = mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory responder and completion monitor.
  int          wcnt = 0;
  int          lat = 0;
  bit          tracking = 0;
  bit          stable_ok = 1;
  logic [48:0] cap;
  bit          wr_seen = 0;
  logic [31:0] wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  end

  always @(negedge clock) begin
    logic [W-1:0] e;
    if (rst) begin
      mem_ack  = 1'b0;
      wcnt     = 0;
      tracking = 0;
    end else begin
      if (tracking) lat++;
      if (done || err) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion: done=%0b err=%0b, expected nothing", done, err);
        end else begin
          e = exp_q.pop_front();
          check("err_vs_done", {62'd0, err, done}, {62'd0, e[40], ~e[40]});
          check("latency", lat, e[51:44]);
          check("t_we", t_we, e[43]);
          check("t_val", t_val, e[42]);
          check("read_addr", rd_addr, e[39:8]);
          check("write_seen", wr_seen, e[41]);
          if (e[41]) begin
            check("write_addr", wr_addr, e[39:8]);
            check("write_data", wr_data, e[7:0]);
          end
          if (e[40]) check("req_dropped_on_err", mem_req, 0);
        end
        tracking = 0;
      end
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wcnt == 0) begin
          cap       = {mem_we, mem_addr, mem_wdata};
          stable_ok = 1;
        end else if ({mem_we, mem_addr, mem_wdata} !== cap) begin
          stable_ok = 0;
        end
        if (wcnt == (mem_we ? wr_waits : rd_waits)) begin
          mem_ack = 1'b1;
          check("req_stable", stable_ok, 1);
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_seen = 1;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
          end else begin
            mem_rdata = rd_mem(mem_addr);
            rd_addr   = mem_addr;
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (start && ready) begin
        tracking = 1;
        lat      = 0;
        wr_seen  = 0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
      end
    end
  end

  // Driver tasks: entered and left at posedge+#1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] g,
                       input logic [7:0] i, input int rw, input int ww,
                       input logic [W-1:0] e, input bit hold);
    check("ready_before_start", ready, 1);
    rd_waits = rw;
    wr_waits = ww;
    exp_q.push_back(e);
    op    = o;
    r0    = a;
    gbr   = g;
    imm   = i;
    start = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    op  = ~o;
    r0  = 32'hDEAD_BEEF;
    gbr = 32'h1234_5678;
    imm = 8'h5A;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; r0 = '0; gbr = '0; imm = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err, 0);
    check("rst_t_we", t_we, 0);
    check("rst_state", dut_state, 0);
    check("rst_alu_op_a", alu_op_a, 0);
    check("rst_alu_operation", alu_operation, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("carry_in", alu_carry_in, 0);
    rst = 1'b0;

    // AND zero-wait: 0xA5 & 0x0F.
    mem[32'h120] = 8'hA5;
    issue(2'b00, 32'h100, 32'h20, 8'h0F, 0, 0, mk_exp(5, 0, 0, 1, 0, 32'h120, 8'h05), 0);
    wait_idle();

    // XOR with 3 read and 2 write wait states.
    mem[32'h200] = 8'hFF;
    issue(2'b10, 32'h1F0, 32'h10, 8'h0F, 3, 2, mk_exp(10, 0, 0, 1, 0, 32'h200, 8'hF0), 0);
    wait_idle();

    // TST, result zero then nonzero.
    mem[32'h300] = 8'hF0;
    issue(2'b11, 32'h300, 32'h0, 8'h0F, 0, 0, mk_exp(4, 1, 1, 0, 0, 32'h300, 8'h00), 0);
    wait_idle();
    issue(2'b11, 32'h300, 32'h0, 8'h10, 0, 0, mk_exp(4, 1, 0, 0, 0, 32'h300, 8'h00), 0);
    wait_idle();
    check("tst_no_write", rd_mem(32'h300), 8'hF0);

    // Address wrap with start held for the whole operation.
    mem[32'h1] = 8'h30;
    issue(2'b01, 32'hFFFF_FFFF, 32'h2, 8'h05, 0, 0, mk_exp(5, 0, 0, 1, 0, 32'h1, 8'h35), 1);
    wait_idle();

    // Reset during a read wait: request and operation are abandoned.
    mem[32'h700] = 8'h77;
    issue(2'b00, 32'h700, 32'h0, 8'h0F, 50, 0, mk_exp(5, 0, 0, 1, 0, 32'h700, 8'h07), 0);
    repeat (3) @(posedge clock);
    #1;
    check("rd_wait_req", mem_req, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_ready", ready, 1);
    check("async_rst_done", done, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    // Normal operation after reset, with read waits.
    mem[32'h15] = 8'h3C;
    issue(2'b00, 32'h10, 32'h5, 8'h0F, 2, 0, mk_exp(7, 0, 0, 1, 0, 32'h15, 8'h0C), 0);
    wait_idle();

`ifdef GBR_RMW_TIMEOUT_EN
    // Read never acknowledged: abort after 16 wait cycles, then a fresh op runs.
    issue(2'b00, 32'h500, 32'h0, 8'h00, 100000, 0, mk_exp(18, 0, 0, 0, 1, 32'h0, 8'h00), 0);
    wait_idle();
    mem[32'h501] = 8'hFF;
    issue(2'b00, 32'h501, 32'h0, 8'h81, 0, 0, mk_exp(5, 0, 0, 1, 0, 32'h501, 8'h81), 0);
    wait_idle();
`endif

    repeat (4) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gbr_rmw_ctrl.md
# gbr_rmw_ctrl

Multi-cycle sequencer for the GBR-indexed byte read-modify-write instructions (AND.B, OR.B, XOR.B, TST.B #imm,@(R0,GBR)). It borrows the execute-stage ALU twice: once to form the effective address R0+GBR, and once to apply the logic operation. Between those uses it runs the byte read and write handshakes on the data-memory port. It sits beside the ALU in the execute stage and holds the pipeline (ready low) while busy.

## Interface
- REG_WIDTH, 32, datapath and address width
- TIMEOUT_CYCLES, 16, memory-ack watchdog limit; used only when GBR_RMW_TIMEOUT_EN is defined
- clock  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted when start && ready
- op  in  2  00 AND, 01 OR, 10 XOR, 11 TST
- r0, gbr  in  REG_WIDTH  operands, captured on accept
- imm  in  8  immediate, captured on accept
- ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- t_we, t_val  out  1, 1  T-bit write strobe and value; TST only, pulsed with done
- err  out  1  one-cycle timeout-abort pulse
- alu_op_a, alu_op_b, alu_operation  out  REG_WIDTH  ALU drive
- alu_carry_in  out  1  always 0
- alu_result  in  REG_WIDTH  combinational ALU result for the current drive
- mem_req, mem_we  out  1, 1  byte access request and write enable
- mem_addr  out  REG_WIDTH  byte address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  access complete; ignored while mem_req is low

## Operation
- FSM states: IDLE, ADDR, RD, OP, WR, DONE.
- IDLE: ready=1. On start, capture op/r0/gbr/imm and go to ADDR. start while busy is ignored (no queueing).
- ADDR: drive alu_operation=ALU_ADD, op_a=r0, op_b=gbr. Latch alu_result as addr, then go to RD. Address is modulo 2^REG_WIDTH; carry is discarded.
- RD: mem_req=1, mem_we=0, mem_addr=addr. On mem_ack, latch mem_rdata and go to OP.
- OP: drive the op's ALU code with op_a and op_b as the zero-extended byte and zero-extended imm. TST uses ALU_AND.
  - AND/OR/XOR: latch result[7:0] and go to WR.
  - TST: t_val = (result[7:0]==0), then go to DONE with no write.
- WR: mem_req=1, mem_we=1, mem_wdata=latched result. On mem_ack, go to DONE.
- DONE: done=1. For TST, t_we=1 also. Next state is IDLE.
- ALU drives are 0 / ALU_ADD outside ADDR and OP. The ALU is never driven in two states at once.

## Timing
- Reset values: state IDLE, ready=1, all other outputs 0, internal registers 0.
- Reset is asynchronous. Asserting it mid-operation drops mem_req in the same cycle and abandons the access. A write aborted before ack has undefined memory effect, and that is accepted.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from the first request cycle until the cycle mem_ack is sampled high.
- mem_ack in the same cycle as the request is legal (zero-wait).
- Zero-wait latency from the accept edge: done high in cycle 5 for AND/OR/XOR, cycle 4 for TST. Each wait state adds 1.
- Back-to-back: ready returns in the cycle after done, so the next start is accepted one cycle after done.

## Configuration
- GBR_RMW_TIMEOUT_EN defined:
  - A counter clears on entry to RD/WR and increments each cycle mem_ack is low.
  - When it reaches TIMEOUT_CYCLES, drop mem_req, pulse err for one cycle and go to IDLE.
  - done and t_we are not asserted in that case.
- GBR_RMW_TIMEOUT_EN undefined: the block waits forever, err is tied 0, and no counter is built.

## Structure
- Shared package cpu_pkg holds:
  - ALU operation codes (ALU_ADD, ALU_AND, ALU_OR, ALU_XOR), also used by alu;
  - rmw_op_t enum for op;
  - rmw_state_t enum.
- Single module; no sub-module is warranted. The ALU is external and shared through a mux owned by the execute stage.

## Test plan
- AND, zero-wait: r0=0x100, gbr=0x20, imm=0x0F, mem[0x120]=0xA5 -> read at 0x120, write 0x05, done in cycle 5, t_we=0.
- XOR with 3 read and 2 write wait states: mem=0xFF, imm=0x0F -> write 0xF0, done in cycle 10, request signals stable throughout the waits.
- TST: mem=0xF0, imm=0x0F -> no write, t_we=1, t_val=1, done in cycle 4. Repeat with imm=0x10 -> t_val=0.
- Address wrap: r0=0xFFFFFFFF, gbr=0x2 -> mem_addr=0x1. start held high during busy -> exactly one operation runs.
- Reset asserted during RD wait -> mem_req low in the same cycle, ready=1, no done.
- GBR_RMW_TIMEOUT_EN with ack never returned -> err pulses after 16 wait cycles, mem_req drops, no done, next start accepted.
